axi_write_queue: RTL and testbench

Buffered request source for the low-priority (FSM) port of the AXI-lite write arbiter. Producers push {address, data} write entries into a FIFO. The block presents the entries one at a time on a req/ack handshake, in push order. It guarantees a stable address and data while a request is pending, and the one-cycle request gap the arbiter needs between transactions.

---
 rtl/axi_write_queue_pkg.sv | 28 ++
 rtl/axi_wq_fifo.sv | 60 ++++++
 rtl/axi_write_queue.sv | 144 ++++++++++++++
 tb/tb_axi_write_queue.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_write_queue_pkg.sv
// ----------------------------------------------------------------------------
// axi_write_queue_pkg
// Shared types for the AXI-lite write queue: FSM state encoding, the default
// queue entry layout and the pointer-width helper used by the FIFO and top.
// ----------------------------------------------------------------------------
package axi_write_queue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } wq_state_t;

    localparam int WQ_ADDR_W = 32;
    localparam int WQ_DATA_W = 32;

    // Default entry layout; the top re-declares it with its own widths.
    typedef struct packed {
        logic [WQ_ADDR_W-1:0] adress;
        logic [WQ_DATA_W-1:0] data;
    } wq_entry_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int wq_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi_wq_fifo.sv
// ----------------------------------------------------------------------------
// axi_wq_fifo
// Synchronous DEPTH-entry FIFO of queue entries with push/pop/clear.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_entry write an entry (ignored when full or clearing)
//   pop             drop the head entry (ignored when empty)
//   clear           empty the FIFO; overrides push and pop
//   head            entry at the read pointer
//   full, empty     occupancy flags from registered pointers
//   count           number of stored entries
// ----------------------------------------------------------------------------
module axi_wq_fifo
    import axi_write_queue_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wq_entry_t
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  entry_t                      push_entry,
    input  logic                        pop,
    input  logic                        clear,
    output entry_t                      head,
    output logic                        full,
    output logic                        empty,
    output logic [wq_ptr_w(DEPTH)-1:0]  count
);

    localparam int PW = wq_ptr_w(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
    assign empty   = (wptr == rptr);
    assign count   = wptr - rptr;
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;
    assign head    = mem[rptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[PW-2:0]] <= push_entry;
    end

endmodule

// File: rtl/axi_write_queue.sv
// ----------------------------------------------------------------------------
// axi_write_queue
// Buffered write-request source for the low-priority arbiter port. Entries
// are queued and offered one at a time on a req/ack handshake, in push order,
// with one idle cycle between requests.
//
//   state | meaning
//   IDLE  | no request; waits for a queued entry and no pending flush
//   REQ   | head entry offered, held stable until wr_ack_i
//   GAP   | one-cycle request gap after an accepted write
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   push_valid_i / push_ready_i   producer handshake (ready = not full)
//   push_adress_i, push_data_i    entry to queue
//   wr_adress_o, wr_data_o        head entry while requesting, else 0
//   wr_req_o, wr_ack_i            arbiter handshake
//   flush_i                       discard queued entries
//   clear_err_i                   clear sticky error flags
//   count_o, empty_o              occupancy
//   overflow_o, spurious_ack_o    sticky error flags
// ----------------------------------------------------------------------------
module axi_write_queue
    import axi_write_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid_i,
    output logic                    push_ready_i,
    input  logic [ADDR_W-1:0]       push_adress_i,
    input  logic [DATA_W-1:0]       push_data_i,
    output logic [ADDR_W-1:0]       wr_adress_o,
    output logic [DATA_W-1:0]       wr_data_o,
    output logic                    wr_req_o,
    input  logic                    wr_ack_i,
    input  logic                    flush_i,
    input  logic                    clear_err_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o,
    output logic                    overflow_o,
    output logic                    spurious_ack_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] adress;
        logic [DATA_W-1:0] data;
    } entry_t;

    wq_state_t  state;
    wq_state_t  state_next;
    entry_t     push_entry;
    entry_t     head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       in_req;
    logic       ack_pop;
    logic       flush_pend;
    logic       flush_exec;
    logic       push_en;

    assign in_req     = (state == REQ);
    assign ack_pop    = in_req && wr_ack_i;
    // A flush outside REQ acts immediately; inside REQ it waits for the ack
    // so the arbiter never sees a request withdrawn.
    assign flush_exec = (flush_i && !in_req) || (ack_pop && (flush_pend || flush_i));
    assign push_en    = push_valid_i && !fifo_full && !flush_exec;
    assign push_entry = '{adress: push_adress_i, data: push_data_i};

    assign push_ready_i = !fifo_full;
    assign empty_o      = fifo_empty;

    axi_wq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_en),
        .push_entry (push_entry),
        .pop        (ack_pop),
        .clear      (flush_exec),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (count_o)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!flush_i && !fifo_empty && !flush_pend) state_next = REQ;
            end
            REQ: begin
                if (wr_ack_i) state_next = GAP;
            end
            GAP: begin
                if (!flush_i && !fifo_empty && !flush_pend) state_next = REQ;
                else                                        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_req_o    = 1'b0;
        wr_adress_o = '0;
        wr_data_o   = '0;
        if (state == REQ) begin
            wr_req_o    = 1'b1;
            wr_adress_o = head.adress;
            wr_data_o   = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                  flush_pend <= 1'b0;
        else if (flush_exec)      flush_pend <= 1'b0;
        else if (flush_i && in_req) flush_pend <= 1'b1;
    end

    // Set has priority over clear so a same-cycle event is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o     <= 1'b0;
            spurious_ack_o <= 1'b0;
        end else begin
            if (push_valid_i && fifo_full) overflow_o <= 1'b1;
            else if (clear_err_i)          overflow_o <= 1'b0;
            if (wr_ack_i && !in_req)       spurious_ack_o <= 1'b1;
            else if (clear_err_i)          spurious_ack_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_write_queue.sv
module tb_axi_write_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid_i = 1'b0;
    logic        push_ready_i;
    logic [31:0] push_adress_i = '0;
    logic [31:0] push_data_i = '0;
    logic [31:0] wr_adress_o;
    logic [31:0] wr_data_o;
    logic        wr_req_o;
    logic        wr_ack_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        clear_err_i = 1'b0;
    logic [2:0]  count_o;
    logic        empty_o;
    logic        overflow_o;
    logic        spurious_ack_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [63:0] exp_q[$];
    int rise_q[$];

    axi_write_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .push_valid_i   (push_valid_i),
        .push_ready_i   (push_ready_i),
        .push_adress_i  (push_adress_i),
        .push_data_i    (push_data_i),
        .wr_adress_o    (wr_adress_o),
        .wr_data_o      (wr_data_o),
        .wr_req_o       (wr_req_o),
        .wr_ack_i       (wr_ack_i),
        .flush_i        (flush_i),
        .clear_err_i    (clear_err_i),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .overflow_o     (overflow_o),
        .spurious_ack_o (spurious_ack_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        push_valid_i = 1'b0;
        wr_ack_i = 1'b0;
        flush_i = 1'b0;
        clear_err_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        rise_q.delete();
    endtask

    task automatic wait_req(input string name);
        int waited;
        waited = 0;
        while (!wr_req_o && waited < 50) begin
            step();
            waited++;
        end
        if (!wr_req_o) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got req=0 expected req=1", name);
        end
    endtask

    // Acks each request one cycle after it is first seen.
    task automatic serve(input int n);
        for (int k = 0; k < n; k++) begin
            wait_req("serve");
            if (!wr_req_o) return;
            step();
            wr_ack_i = 1'b1;
            step();
            wr_ack_i = 1'b0;
        end
    endtask

    // Monitor: each new request is matched against the expected queue, the
    // bus must hold while requesting and read zero otherwise.
    initial begin
        logic        prev_req;
        logic [63:0] held;
        logic [63:0] cur;
        logic [63:0] e;
        prev_req = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cur = {wr_adress_o, wr_data_o};
            if (wr_req_o && !prev_req) begin
                rise_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got 0x%0h expected no request", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_entry", cur, e);
                end
                held = cur;
            end else if (wr_req_o) begin
                chk("req_hold", cur, held);
            end else if (cur != 64'h0) begin
                chk("idle_bus_zero", cur, 64'h0);
            end
            prev_req = wr_req_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_ready", 64'(push_ready_i), 64'd1);
        chk("rst_req", 64'(wr_req_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_spurious", 64'(spurious_ack_o), 64'd0);
        chk("rst_bus", {wr_adress_o, wr_data_o}, 64'h0);

        // 1: single entry latency and ack
        push_valid_i = 1'b1;
        push_adress_i = 32'h0000_1000;
        push_data_i = 32'hDEAD_BEEF;
        exp_q.push_back({32'h0000_1000, 32'hDEAD_BEEF});
        step();
        push_valid_i = 1'b0;
        chk("t1_req_c1", 64'(wr_req_o), 64'd0);
        chk("t1_count_c1", 64'(count_o), 64'd1);
        step();
        chk("t1_req_c2", 64'(wr_req_o), 64'd1);
        step();
        wr_ack_i = 1'b1;
        step();
        wr_ack_i = 1'b0;
        chk("t1_req_c4", 64'(wr_req_o), 64'd0);
        chk("t1_count_c4", 64'(count_o), 64'd0);
        chk("t1_empty_c4", 64'(empty_o), 64'd1);
        step();

        // Flush while IDLE with one entry queued; concurrent push discarded
        push_valid_i = 1'b1;
        push_adress_i = 32'h0000_2000;
        push_data_i = 32'h1111_2222;
        step();
        push_adress_i = 32'h0000_2004;
        flush_i = 1'b1;
        step();
        push_valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_idle_count", 64'(count_o), 64'd0);
        chk("flush_idle_req", 64'(wr_req_o), 64'd0);
        step();
        chk("flush_idle_req2", 64'(wr_req_o), 64'd0);

        // 2: overflow with DEPTH=4, then 6: push and ack while full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_valid_i = 1'b1;
            push_adress_i = 32'h0000_0100 + 32'(i * 4);
            push_data_i = 32'hA000_0000 + 32'(i);
            if (i < 4) exp_q.push_back({32'h0000_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i)});
            if (i == 3) chk("t2_ready_at3", 64'(push_ready_i), 64'd1);
            if (i == 4) chk("t2_ready_full", 64'(push_ready_i), 64'd0);
            step();
        end
        push_valid_i = 1'b0;
        chk("t2_overflow", 64'(overflow_o), 64'd1);
        chk("t2_count", 64'(count_o), 64'd4);
        chk("t2_ready_after", 64'(push_ready_i), 64'd0);
        clear_err_i = 1'b1;
        step();
        clear_err_i = 1'b0;
        chk("t2_overflow_clr", 64'(overflow_o), 64'd0);
        chk("t6_in_req", 64'(wr_req_o), 64'd1);
        push_valid_i = 1'b1;
        push_adress_i = 32'h0000_0EEE;
        push_data_i = 32'hBAD0_BAD0;
        wr_ack_i = 1'b1;
        step();
        push_valid_i = 1'b0;
        wr_ack_i = 1'b0;
        chk("t6_overflow", 64'(overflow_o), 64'd1);
        chk("t6_count", 64'(count_o), 64'd3);
        chk("t6_ready", 64'(push_ready_i), 64'd1);
        serve(3);
        step();
        chk("t6_drain_count", 64'(count_o), 64'd0);
        chk("t6_drain_exp", 64'(exp_q.size()), 64'd0);

        // 3: three entries, each request separated by one GAP cycle
        do_reset();
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    push_valid_i = 1'b1;
                    push_adress_i = 32'h0000_A000 + 32'(i * 16);
                    push_data_i = 32'hC0DE_0000 + 32'(i);
                    exp_q.push_back({32'h0000_A000 + 32'(i * 16), 32'hC0DE_0000 + 32'(i)});
                    step();
                end
                push_valid_i = 1'b0;
            end
            serve(3);
        join
        step();
        chk("t3_nreq", 64'(rise_q.size()), 64'd3);
        if (rise_q.size() == 3) begin
            chk("t3_spacing_ab", 64'(rise_q[1] - rise_q[0]), 64'd3);
            chk("t3_spacing_bc", 64'(rise_q[2] - rise_q[1]), 64'd3);
        end
        chk("t3_count", 64'(count_o), 64'd0);

        // 4: flush during REQ on A; B and C never requested
        do_reset();
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    push_valid_i = 1'b1;
                    push_adress_i = 32'h0000_B000 + 32'(i * 4);
                    push_data_i = 32'h5EED_0000 + 32'(i);
                    if (i == 0) exp_q.push_back({32'h0000_B000, 32'h5EED_0000});
                    step();
                end
                push_valid_i = 1'b0;
            end
            begin
                wait_req("t4");
                flush_i = 1'b1;
                step();
                flush_i = 1'b0;
                step();
                step();
                chk("t4_hold_req", 64'(wr_req_o), 64'd1);
                wr_ack_i = 1'b1;
                step();
                wr_ack_i = 1'b0;
                chk("t4_gap_req", 64'(wr_req_o), 64'd0);
                chk("t4_count", 64'(count_o), 64'd0);
                step();
                chk("t4_idle_req", 64'(wr_req_o), 64'd0);
                repeat (5) step();
                chk("t4_late_req", 64'(wr_req_o), 64'd0);
                chk("t4_late_count", 64'(count_o), 64'd0);
            end
        join

        // 5: ack while IDLE, then clear/set race
        wr_ack_i = 1'b1;
        step();
        wr_ack_i = 1'b0;
        chk("t5_spurious", 64'(spurious_ack_o), 64'd1);
        chk("t5_count", 64'(count_o), 64'd0);
        wr_ack_i = 1'b1;
        clear_err_i = 1'b1;
        step();
        wr_ack_i = 1'b0;
        clear_err_i = 1'b0;
        chk("t5_set_wins", 64'(spurious_ack_o), 64'd1);
        clear_err_i = 1'b1;
        step();
        clear_err_i = 1'b0;
        chk("t5_cleared", 64'(spurious_ack_o), 64'd0);

        // Reset mid-request, then a late ack
        push_valid_i = 1'b1;
        push_adress_i = 32'h0000_C000;
        push_data_i = 32'h7777_8888;
        exp_q.push_back({32'h0000_C000, 32'h7777_8888});
        step();
        push_valid_i = 1'b0;
        wait_req("t7");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_req_drop", 64'(wr_req_o), 64'd0);
        chk("t7_count", 64'(count_o), 64'd0);
        wr_ack_i = 1'b1;
        step();
        wr_ack_i = 1'b0;
        chk("t7_late_ack", 64'(spurious_ack_o), 64'd1);
        chk("t7_count_after", 64'(count_o), 64'd0);

        step();
        chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
